digit_scan_ctrl: RTL and testbench

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

---
 rtl/digit_scan_pkg.sv | 21 ++
 rtl/slot_timer.sv | 28 ++
 rtl/digit_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the four-digit multiplexed display scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package digit_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  // BCD nibble of digit idx out of the packed four-digit word.
  function automatic logic [DIGIT_W-1:0] nibble_of(input logic [15:0] word,
                                                   input logic [1:0]  idx);
    return word[{idx, 2'b00} +: DIGIT_W];
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter timing the BLANK and ON slots; tc flags a zero count.
// Latency: load takes effect on the next edge; tc is decoded from the count register.
// Backpressure: none; counts every cycle it is not loaded, holds at zero.
module slot_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  // A load always wins; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else if (load)
      cnt_q <= load_val;
    else if (cnt_q != '0)
      cnt_q <= cnt_q - 1'b1;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Scans four BCD digits onto a 2-to-4 decoder with dead time between digits; optional leading-zero blanking under DIGIT_SCAN_LZB_EN.
// Latency: all outputs registered; first lit digit BLANK_CYCLES+1 cycles after run rises.
// Backpressure: none; run low returns to IDLE on the next edge.
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  output logic        A,
  output logic        B,
  output logic        en,
  output logic [3:0]  nibble,
  output logic        frame_done
);

  // Counter must hold the larger of the two slot lengths without wrapping.
  localparam int MAXV = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] ON_LOAD    = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  state_t          state_q, state_n;
  logic [1:0]      idx_q, idx_n;
  logic [15:0]     snap_q, snap_n;
  logic [3:0]      mask_q, mask_n;
  logic            en_n, fd_n, lit;
  logic [3:0]      nib_n;
  logic            load, tc;
  logic [CW-1:0]   load_val;

`ifdef DIGIT_SCAN_LZB_EN
  // True when digit i and every digit above it are zero; digit 0 always shows.
  function automatic logic lead_zero(input logic [15:0] snap, input logic [1:0] i);
    return (i != 2'd0) && ((snap >> {i, 2'b00}) == 16'h0000);
  endfunction
`endif

  slot_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  // Next-state, slot loading and next registered outputs.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    snap_n   = snap_q;
    mask_n   = mask_q;
    load     = 1'b0;
    load_val = '0;
    fd_n     = 1'b0;
    if (!run) begin
      state_n = IDLE;
      idx_n   = 2'd0;
      load    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          idx_n  = 2'd0;
          snap_n = digits;
          mask_n = digit_en;
          load   = 1'b1;
          if (BLANK_CYCLES > 0) begin
            state_n  = BLANK;
            load_val = BLANK_LOAD;
          end else begin
            state_n  = ON;
            load_val = ON_LOAD;
          end
        end
        BLANK: begin
          if (tc) begin
            state_n  = ON;
            load     = 1'b1;
            load_val = ON_LOAD;
          end
        end
        ON: begin
          if (tc) begin
            idx_n = idx_q + 2'd1;
            fd_n  = (idx_q == 2'd3);
            load  = 1'b1;
            // New frame: freeze the digits and mask for all four slots.
            if (idx_n == 2'd0) begin
              snap_n = digits;
              mask_n = digit_en;
            end
            if (BLANK_CYCLES > 0) begin
              state_n  = BLANK;
              load_val = BLANK_LOAD;
            end else begin
              state_n  = ON;
              load_val = ON_LOAD;
            end
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = 2'd0;
          load    = 1'b1;
        end
      endcase
    end
    // Select and nibble move together; en is only raised in ON.
    nib_n = nibble_of(snap_n, idx_n);
    lit   = mask_n[idx_n];
`ifdef DIGIT_SCAN_LZB_EN
    if (lead_zero(snap_n, idx_n))
      lit = 1'b0;
`endif
    en_n  = (state_n == ON) && lit;
  end

  // State, frame snapshot and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      snap_q     <= '0;
      mask_q     <= '0;
      en         <= 1'b0;
      nibble     <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      snap_q     <= snap_n;
      mask_q     <= mask_n;
      en         <= en_n;
      nibble     <= nib_n;
      frame_done <= fd_n;
    end
  end

  assign A = idx_q[1];
  assign B = idx_q[0];

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with a per-cycle expected-output scoreboard.
// Latency: expectations are queued before each edge and compared 1 time unit after it.
// Backpressure: n/a.
module tb_digit_scan_ctrl;

  localparam int PRESCALE     = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int SLOT         = PRESCALE + BLANK_CYCLES;
  localparam int FRAME        = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  digit_en = 4'h0;
  logic        A, B, en, frame_done;
  logic [3:0]  nibble;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected {A,B,en,nibble,frame_done}, pushed when stimulus is applied.
  logic [7:0] exp_q[$];

  // Reference position: cycles since run started (-1 = idle/reset).
  int          p      = -1;
  logic [15:0] m_snap = 16'h0000;
  logic [3:0]  m_msk  = 4'h0;

  digit_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .digits     (digits),
    .digit_en   (digit_en),
    .A          (A),
    .B          (B),
    .en         (en),
    .nibble     (nibble),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Outputs expected after the next edge, from the current inputs.
  task automatic model_step(output logic [7:0] e);
    int         slot, ph;
    logic       lit, fd;
    logic [1:0] sl;
    logic [3:0] nib;
    if (!run) begin
      p = -1;
      e = {2'b00, 1'b0, m_snap[3:0], 1'b0};
    end else begin
      p = p + 1;
      if (p % FRAME == 0) begin
        m_snap = digits;
        m_msk  = digit_en;
      end
      slot = (p / SLOT) % 4;
      ph   = p % SLOT;
      lit  = (ph >= BLANK_CYCLES) && m_msk[slot];
`ifdef DIGIT_SCAN_LZB_EN
      if (slot != 0 && (m_snap >> (4 * slot)) == 16'h0000)
        lit = 1'b0;
`endif
      fd  = (p % FRAME == 0) && (p > 0);
      sl  = slot[1:0];
      nib = m_snap[4 * slot +: 4];
      e   = {sl, lit, nib, fd};
    end
  endtask

  task automatic check_out(input string tag);
    logic [7:0] got, e;
    got = {A, B, en, nibble, frame_done};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s cycle %0d: nothing queued, got %b", tag, cyc, got);
    end else begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        errors++;
        $error("FAIL %s cycle %0d: {A,B,en,nibble,fd} got %b required %b", tag, cyc, got, e);
      end
    end
  endtask

  // One clocked cycle: queue expectation at the negedge, compare after the posedge.
  task automatic step(input string tag);
    logic [7:0] e;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    check_out(tag);
    @(negedge clk);
  endtask

  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic run_to(input int ph, input string tag);
    for (int i = 0; i < FRAME && (p % FRAME) != ph; i++) step(tag);
  endtask

  initial begin
    // Reset state, asserted asynchronously and then held across an edge.
    #1 reset = 1'b1;
    #2;
    exp_q.push_back(8'h00);
    check_out("reset_async");
    @(posedge clk);
    #1;
    exp_q.push_back(8'h00);
    check_out("reset_held");
    @(negedge clk);

    // Basic scan: 00,01,10,11 select order, nibble 1..4, 4 on / 2 dark.
    digits   = 16'h4321;
    digit_en = 4'hF;
    run      = 1'b1;
    reset    = 1'b0;
    run_n(50, "scan_4321");

    // Masked digits stay dark; change lands at the next frame boundary.
    digit_en = 4'b1010;
    run_n(50, "mask_1010");
    digit_en = 4'hF;

    // Mid-frame digit change must not show until the next idx 0 slot.
    run_to(8, "to_idx1");
    digits = 16'h9999;
    run_n(30, "snap_hold");
    digits = 16'h4321;
    run_n(24, "snap_back");

    // run dropped mid-ON of idx 2, then restarted.
    run_to(15, "to_idx2");
    run = 1'b0;
    step("run_drop");
    run_n(3, "run_idle");
    run = 1'b1;
    run_n(30, "run_restart");

    // Reset pulsed mid-ON of idx 2: outputs clear without a clock edge.
    run_to(15, "to_idx2_rst");
    reset = 1'b1;
    #1;
    p      = -1;
    m_snap = 16'h0000;
    m_msk  = 4'h0;
    exp_q.push_back(8'h00);
    check_out("reset_mid_on");
    @(negedge clk);
    reset = 1'b0;
    run_n(30, "after_reset");

    // Leading zeros: digits 3 and 2 dark only when blanking is built in.
    digits = 16'h0050;
    run_n(50, "lzb_0050");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
